// File: rtl/vga_timing_gen_pkg.sv
// Shared constants and types for the VGA raster timing generator.
// Default 640x480@60 geometry plus the swap-control state encoding.
package vga_timing_gen_pkg;

  localparam int DEF_W_VIS       = 640;
  localparam int DEF_H_VIS       = 480;
  localparam int DEF_H_TOTAL     = 640 + 16 + 96 + 48;
  localparam int DEF_V_TOTAL     = 480 + 10 + 2 + 33;
  localparam int DEF_HSYNC_START = 640 + 16;
  localparam int DEF_HSYNC_END   = 640 + 16 + 96 - 1;
  localparam int DEF_VSYNC_START = 480 + 10;
  localparam int DEF_VSYNC_END   = 480 + 10 + 2 - 1;

  typedef enum logic {
    SW_IDLE = 1'b0,
    SW_PEND = 1'b1
  } swap_state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: the generator drives timing/status, the draw engine drives swap_req.
interface vga_timing_gen_if
  import vga_timing_gen_pkg::*;
  #(
    parameter int HC_W   = cnt_w(DEF_H_TOTAL),
    parameter int VC_W   = cnt_w(DEF_V_TOTAL),
    parameter int FCNT_W = 16
  ) ();

  logic              swap_req;
  logic [HC_W-1:0]   h_cnt;
  logic [VC_W-1:0]   v_cnt;
  logic              h_sync;
  logic              v_sync;
  logic              video_active;
  logic              line_start;
  logic              frame_start;
  logic              vblank_start;
  logic              fb_sel;
  logic              swap_pending;
  logic              swap_ack;
  logic [FCNT_W-1:0] frame_cnt;

  modport master (
    input  swap_req,
    output h_cnt, v_cnt, h_sync, v_sync, video_active,
    output line_start, frame_start, vblank_start,
    output fb_sel, swap_pending, swap_ack, frame_cnt
  );

  modport slave (
    output swap_req,
    input  h_cnt, v_cnt, h_sync, v_sync, video_active,
    input  line_start, frame_start, vblank_start,
    input  fb_sel, swap_pending, swap_ack, frame_cnt
  );

endinterface

// File: rtl/vga_timing_gen_axis_counter.sv
// Wrapping 0..MAX-1 counter; exposes the next value so decode can be registered with zero skew.
module vga_axis_counter #(
  parameter int MAX = 800,
  parameter int W   = 10
) (
  input  logic         pix_clk,
  input  logic         prst,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt,
  output logic [W-1:0] o_nxt,
  output logic         o_wrap
);

  logic [W-1:0] r_cnt;
  logic         w_last;

  always_comb begin
    w_last = (r_cnt == W'(MAX - 1));
    o_wrap = i_inc && w_last;
    if (!i_inc)      o_nxt = r_cnt;
    else if (w_last) o_nxt = '0;
    else             o_nxt = r_cnt + W'(1);
  end

  always_ff @(posedge pix_clk or posedge prst) begin
    if (prst) r_cnt <= '0;
    else      r_cnt <= o_nxt;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source with tear-free front/back framebuffer swap at start of vertical blank.
// Every flag is decoded from the counters' next value and registered alongside them.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
  #(
    parameter int W_VIS         = DEF_W_VIS,
    parameter int H_VIS         = DEF_H_VIS,
    parameter int H_FRONT_PORCH = 16,
    parameter int H_SYNC_PULSE  = 96,
    parameter int H_BACK_PORCH  = 48,
    parameter int V_FP          = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BP          = 33,
    parameter int FCNT_W        = 16
  ) (
    input  logic             pix_clk,
    input  logic             prst,
    vga_timing_gen_if.master vga
  );

  localparam int H_TOTAL     = W_VIS + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
  localparam int V_TOTAL     = H_VIS + V_FP + V_SYNC + V_BP;
  localparam int HC_W        = cnt_w(H_TOTAL);
  localparam int VC_W        = cnt_w(V_TOTAL);
  localparam int HSYNC_START = W_VIS + H_FRONT_PORCH;
  localparam int HSYNC_END   = HSYNC_START + H_SYNC_PULSE - 1;
  localparam int VSYNC_START = H_VIS + V_FP;
  localparam int VSYNC_END   = VSYNC_START + V_SYNC - 1;

  logic [HC_W-1:0]   w_h_cnt, w_h_nxt;
  logic [VC_W-1:0]   w_v_cnt, w_v_nxt;
  logic              w_h_wrap, w_v_wrap;

  logic              w_hsync_n_p0, w_vsync_n_p0, w_active_p0;
  logic              w_line_p0, w_frame_p0, w_vblank_p0;

  logic              r_hsync_n_p1, r_vsync_n_p1, r_active_p1;
  logic              r_line_p1, r_frame_p1, r_vblank_p1;
  logic [FCNT_W-1:0] r_frame_cnt;

  swap_state_t       r_sw_state, w_sw_state_nxt;
  logic              w_do_swap, w_swap_pending;
  logic              r_fb_sel, r_swap_ack;

  vga_axis_counter #(.MAX(H_TOTAL), .W(HC_W)) u_h_cnt (
    .pix_clk (pix_clk),
    .prst    (prst),
    .i_inc   (1'b1),
    .o_cnt   (w_h_cnt),
    .o_nxt   (w_h_nxt),
    .o_wrap  (w_h_wrap)
  );

  vga_axis_counter #(.MAX(V_TOTAL), .W(VC_W)) u_v_cnt (
    .pix_clk (pix_clk),
    .prst    (prst),
    .i_inc   (w_h_wrap),
    .o_cnt   (w_v_cnt),
    .o_nxt   (w_v_nxt),
    .o_wrap  (w_v_wrap)
  );

  // Stage p0: decode the position the counters are about to take
  always_comb begin
    w_hsync_n_p0 = !((w_h_nxt >= HC_W'(HSYNC_START)) && (w_h_nxt <= HC_W'(HSYNC_END)));
    w_vsync_n_p0 = !((w_v_nxt >= VC_W'(VSYNC_START)) && (w_v_nxt <= VC_W'(VSYNC_END)));
    w_active_p0  = (w_h_nxt < HC_W'(W_VIS)) && (w_v_nxt < VC_W'(H_VIS));
    w_line_p0    = (w_h_nxt == '0);
    w_frame_p0   = w_line_p0 && (w_v_nxt == '0);
    w_vblank_p0  = w_line_p0 && (w_v_nxt == VC_W'(H_VIS));
  end

  // Stage p1: flags registered on the same edge as the counters
  always_ff @(posedge pix_clk or posedge prst) begin
    if (prst) begin
      r_hsync_n_p1 <= 1'b1;
      r_vsync_n_p1 <= 1'b1;
      r_active_p1  <= 1'b1;
      r_line_p1    <= 1'b0;
      r_frame_p1   <= 1'b0;
      r_vblank_p1  <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_hsync_n_p1 <= w_hsync_n_p0;
      r_vsync_n_p1 <= w_vsync_n_p0;
      r_active_p1  <= w_active_p0;
      r_line_p1    <= w_line_p0;
      r_frame_p1   <= w_frame_p0;
      r_vblank_p1  <= w_vblank_p0;
      if (w_v_wrap) r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
    end
  end

  // Swap control: state register together with the buffer select and ack it drives
  always_ff @(posedge pix_clk or posedge prst) begin
    if (prst) begin
      r_sw_state <= SW_IDLE;
      r_fb_sel   <= 1'b0;
      r_swap_ack <= 1'b0;
    end else begin
      r_sw_state <= w_sw_state_nxt;
      r_fb_sel   <= r_fb_sel ^ w_do_swap;
      r_swap_ack <= w_do_swap;
    end
  end

  // A request on the vblank edge itself is executed there rather than held for a frame
  always_comb begin
    w_sw_state_nxt = r_sw_state;
    if (w_vblank_p0)       w_sw_state_nxt = SW_IDLE;
    else if (vga.swap_req) w_sw_state_nxt = SW_PEND;
  end

  always_comb begin
    w_swap_pending = (r_sw_state == SW_PEND);
    w_do_swap      = w_vblank_p0 && (w_swap_pending || vga.swap_req);
  end

  assign vga.h_cnt        = w_h_cnt;
  assign vga.v_cnt        = w_v_cnt;
  assign vga.h_sync       = r_hsync_n_p1;
  assign vga.v_sync       = r_vsync_n_p1;
  assign vga.video_active = r_active_p1;
  assign vga.line_start   = r_line_p1;
  assign vga.frame_start  = r_frame_p1;
  assign vga.vblank_start = r_vblank_p1;
  assign vga.fb_sel       = r_fb_sel;
  assign vga.swap_pending = w_swap_pending;
  assign vga.swap_ack     = r_swap_ack;
  assign vga.frame_cnt    = r_frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three geometries checked every cycle against a position-from-time model,
// plus directed swap scenarios and a randomized swap_req phase.
module tb_vga_timing_gen;

  typedef struct { int wv; int hv; int hfp; int hs; int hbp; int vfp; int vs; int vbp; } geom_t;
  typedef struct { int h; int v; int hsn; int vsn; int act; int ls; int fs; int vbs; int fc; } tim_t;
  typedef struct { int fb; int pend; int ack; } sw_t;

  logic pix_clk = 1'b0;
  logic prst;
  always #5 pix_clk = ~pix_clk;

  geom_t ga = '{640, 480, 16, 96, 48, 10, 2, 33};
  geom_t gb = '{16, 12, 2, 4, 3, 2, 2, 3};
  geom_t gc = '{4, 3, 1, 1, 1, 1, 1, 1};

  longint t;
  sw_t    sa, sb, sc;
  int     n_chk  = 0;
  int     n_pass = 0;
  int     n_fail = 0;

  vga_timing_gen_if #(.HC_W(10), .VC_W(10), .FCNT_W(16)) ifa ();
  vga_timing_gen_if #(.HC_W(5),  .VC_W(5),  .FCNT_W(16)) ifb ();
  vga_timing_gen_if #(.HC_W(3),  .VC_W(3),  .FCNT_W(16)) ifc ();

  vga_timing_gen dut_a (.pix_clk(pix_clk), .prst(prst), .vga(ifa));

  vga_timing_gen #(
    .W_VIS(16), .H_VIS(12), .H_FRONT_PORCH(2), .H_SYNC_PULSE(4), .H_BACK_PORCH(3),
    .V_FP(2), .V_SYNC(2), .V_BP(3), .FCNT_W(16)
  ) dut_b (.pix_clk(pix_clk), .prst(prst), .vga(ifb));

  vga_timing_gen #(
    .W_VIS(4), .H_VIS(3), .H_FRONT_PORCH(1), .H_SYNC_PULSE(1), .H_BACK_PORCH(1),
    .V_FP(1), .V_SYNC(1), .V_BP(1), .FCNT_W(16)
  ) dut_c (.pix_clk(pix_clk), .prst(prst), .vga(ifc));

  // Raster position is purely a function of cycles since reset release.
  function automatic tim_t model(input geom_t g, input longint tt);
    tim_t m;
    longint ht, vt;
    ht    = g.wv + g.hfp + g.hs + g.hbp;
    vt    = g.hv + g.vfp + g.vs + g.vbp;
    m.h   = int'(tt % ht);
    m.v   = int'((tt / ht) % vt);
    m.hsn = (m.h >= g.wv + g.hfp && m.h < g.wv + g.hfp + g.hs) ? 0 : 1;
    m.vsn = (m.v >= g.hv + g.vfp && m.v < g.hv + g.vfp + g.vs) ? 0 : 1;
    m.act = (m.h < g.wv && m.v < g.hv) ? 1 : 0;
    m.ls  = (tt > 0 && m.h == 0) ? 1 : 0;
    m.fs  = (m.ls != 0 && m.v == 0) ? 1 : 0;
    m.vbs = (m.ls != 0 && m.v == g.hv) ? 1 : 0;
    m.fc  = int'((tt / (ht * vt)) % 65536);
    return m;
  endfunction

  function automatic sw_t sw_upd(input sw_t s, input int vb, input int req);
    sw_t n;
    n = s;
    if (vb != 0) begin
      n.ack  = (s.pend != 0 || req != 0) ? 1 : 0;
      if (n.ack != 0) n.fb = 1 - s.fb;
      n.pend = 0;
    end else begin
      n.ack = 0;
      if (req != 0) n.pend = 1;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s t=%0d observed=%0d expected=%0d", tag, t, obs, exp);
    end
  endtask

  task automatic chk_dut(input string nm, input geom_t g, input sw_t s,
                         input logic [31:0] h, input logic [31:0] v, input logic [31:0] hsn,
                         input logic [31:0] vsn, input logic [31:0] act, input logic [31:0] ls,
                         input logic [31:0] fs, input logic [31:0] vbs, input logic [31:0] fb,
                         input logic [31:0] pend, input logic [31:0] ack, input logic [31:0] fc);
    tim_t m;
    m = model(g, t);
    chk({nm, ".h_cnt"},        h,    m.h);
    chk({nm, ".v_cnt"},        v,    m.v);
    chk({nm, ".h_sync"},       hsn,  m.hsn);
    chk({nm, ".v_sync"},       vsn,  m.vsn);
    chk({nm, ".video_active"}, act,  m.act);
    chk({nm, ".line_start"},   ls,   m.ls);
    chk({nm, ".frame_start"},  fs,   m.fs);
    chk({nm, ".vblank_start"}, vbs,  m.vbs);
    chk({nm, ".frame_cnt"},    fc,   m.fc);
    chk({nm, ".fb_sel"},       fb,   s.fb);
    chk({nm, ".swap_pending"}, pend, s.pend);
    chk({nm, ".swap_ack"},     ack,  s.ack);
  endtask

  task automatic check_all();
    chk_dut("A", ga, sa, 32'(ifa.h_cnt), 32'(ifa.v_cnt), 32'(ifa.h_sync), 32'(ifa.v_sync),
            32'(ifa.video_active), 32'(ifa.line_start), 32'(ifa.frame_start),
            32'(ifa.vblank_start), 32'(ifa.fb_sel), 32'(ifa.swap_pending),
            32'(ifa.swap_ack), 32'(ifa.frame_cnt));
    chk_dut("B", gb, sb, 32'(ifb.h_cnt), 32'(ifb.v_cnt), 32'(ifb.h_sync), 32'(ifb.v_sync),
            32'(ifb.video_active), 32'(ifb.line_start), 32'(ifb.frame_start),
            32'(ifb.vblank_start), 32'(ifb.fb_sel), 32'(ifb.swap_pending),
            32'(ifb.swap_ack), 32'(ifb.frame_cnt));
    chk_dut("C", gc, sc, 32'(ifc.h_cnt), 32'(ifc.v_cnt), 32'(ifc.h_sync), 32'(ifc.v_sync),
            32'(ifc.video_active), 32'(ifc.line_start), 32'(ifc.frame_start),
            32'(ifc.vblank_start), 32'(ifc.fb_sel), 32'(ifc.swap_pending),
            32'(ifc.swap_ack), 32'(ifc.frame_cnt));
  endtask

  task automatic step();
    tim_t m;
    @(posedge pix_clk);
    t++;
    m  = model(ga, t);
    sa = sw_upd(sa, m.vbs, int'(ifa.swap_req));
    m  = model(gb, t);
    sb = sw_upd(sb, m.vbs, int'(ifb.swap_req));
    m  = model(gc, t);
    sc = sw_upd(sc, m.vbs, int'(ifc.swap_req));
    #1;
    check_all();
  endtask

  // Asserted between clock edges so the checks see the asynchronous clear before any edge.
  task automatic do_reset();
    prst = 1'b1;
    #2;
    t  = 0;
    sa = '{0, 0, 0};
    sb = '{0, 0, 0};
    sc = '{0, 0, 0};
    check_all();
    prst = 1'b0;
  endtask

  task automatic run_until(input int h, input int v);
    tim_t m;
    int   n;
    n = 0;
    m = model(gb, t);
    while ((m.h != h || m.v != v) && n < 1000) begin
      step();
      n++;
      m = model(gb, t);
    end
  endtask

  task automatic pulse_b();
    ifb.swap_req = 1'b1;
    step();
    ifb.swap_req = 1'b0;
  endtask

  initial begin
    int act;
    prst = 1'b1;
    t    = 0;
    ifa.swap_req = 1'b0;
    ifb.swap_req = 1'b0;
    ifc.swap_req = 1'b0;
    @(posedge pix_clk);
    #1;
    do_reset();

    // One full frame of B: active pixel count, frame strobe and counter at the wrap
    act = 0;
    repeat (475) begin
      step();
      act += int'(ifb.video_active);
    end
    chk("B.active_per_frame", 32'(act), 32'd192);
    chk("B.first_frame_start", 32'(ifb.frame_start), 32'd1);
    chk("B.first_frame_cnt", 32'(ifb.frame_cnt), 32'd1);

    // Request mid-frame, executed at vblank
    run_until(5, 10);
    pulse_b();
    chk("T3.pending_next", 32'(ifb.swap_pending), 32'd1);
    run_until(0, 12);
    chk("T3.fb_sel", 32'(ifb.fb_sel), 32'd1);
    chk("T3.swap_ack", 32'(ifb.swap_ack), 32'd1);
    chk("T3.vblank_start", 32'(ifb.vblank_start), 32'd1);
    chk("T3.pending_clr", 32'(ifb.swap_pending), 32'd0);
    step();
    chk("T3.ack_one_cycle", 32'(ifb.swap_ack), 32'd0);

    // Request on the cycle just before the vblank edge
    run_until(24, 11);
    pulse_b();
    chk("T4a.swap_ack", 32'(ifb.swap_ack), 32'd1);
    chk("T4a.fb_sel", 32'(ifb.fb_sel), 32'd0);

    // Three requests in one frame collapse to a single toggle
    run_until(3, 2);
    pulse_b();
    run_until(7, 5);
    pulse_b();
    run_until(9, 8);
    pulse_b();
    run_until(0, 12);
    chk("T4b.fb_sel", 32'(ifb.fb_sel), 32'd1);
    chk("T4b.swap_ack", 32'(ifb.swap_ack), 32'd1);

    // Request after vblank waits a whole frame
    run_until(3, 13);
    pulse_b();
    chk("T4c.pending", 32'(ifb.swap_pending), 32'd1);
    chk("T4c.fb_hold", 32'(ifb.fb_sel), 32'd1);
    run_until(0, 12);
    chk("T4c.fb_sel", 32'(ifb.fb_sel), 32'd0);
    chk("T4c.swap_ack", 32'(ifb.swap_ack), 32'd1);

    // Reset mid-frame discards a pending request
    run_until(0, 4);
    pulse_b();
    run_until(7, 6);
    chk("T5.pending_before", 32'(ifb.swap_pending), 32'd1);
    do_reset();
    chk("T5.h_cnt", 32'(ifb.h_cnt), 32'd0);
    chk("T5.pending", 32'(ifb.swap_pending), 32'd0);
    chk("T5.fb_sel", 32'(ifb.fb_sel), 32'd0);
    run_until(0, 12);
    chk("T5.no_ack", 32'(ifb.swap_ack), 32'd0);
    chk("T5.fb_after", 32'(ifb.fb_sel), 32'd0);

    // Randomized swap requests on all three geometries
    repeat (20000) begin
      ifa.swap_req = ($urandom_range(0, 99) < 2);
      ifb.swap_req = ($urandom_range(0, 99) < 2);
      ifc.swap_req = ($urandom_range(0, 99) < 5);
      step();
    end
    ifa.swap_req = 1'b0;
    ifb.swap_req = 1'b0;
    ifc.swap_req = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
